// File: rtl/layer_addr_gen.sv
// Walks every (output neuron, input) pair of one fully connected layer, driving weight/input/output addresses.
// Latency: first issue one cycle after start; out_we PIPE_LAT cycles after a neuron's last issue; done one cycle after the final out_we.
// Backpressure: stall freezes the issue counters for that cycle; the write pipeline keeps shifting, so a stall becomes a bubble.
module layer_addr_gen #(
    parameter int                 ADDR_W   = 8,
    parameter int                 N_IN     = 4,
    parameter int                 N_OUT    = 4,
    parameter logic [ADDR_W-1:0]  W_BASE   = ADDR_W'(0),
    parameter logic [ADDR_W-1:0]  IN_BASE  = ADDR_W'(0),
    parameter logic [ADDR_W-1:0]  OUT_BASE = ADDR_W'('h10),
    parameter int                 PIPE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              acc_clear,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_wr_addr
);

    localparam int I_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [I_W-1:0]    i_cnt;
    logic [J_W-1:0]    j_cnt;
    logic [ADDR_W-1:0] w_addr_q;
    logic [ADDR_W-1:0] in_addr_q;
    logic [ADDR_W-1:0] out_addr_q;

    logic              accept;
    logic              issue;
    logic              last_in;
    logic              last_issue;
    logic              iss_we;
    logic              pipe_we_o;
    logic              pipe_last_o;
    logic [ADDR_W-1:0] pipe_addr_o;

    // start is only honoured while not busy (IDLE, or the DONE cycle for back-to-back layers)
    assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
    assign issue      = (state == S_RUN) && !stall;
    assign last_in    = (i_cnt == I_LAST);
    assign last_issue = issue && last_in && (j_cnt == J_LAST);
    assign iss_we     = issue && last_in;

    assign busy        = (state == S_RUN) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign addr_valid  = issue;
    assign acc_clear   = issue && (i_cnt == '0);
    assign weight_addr = w_addr_q;
    assign in_addr     = in_addr_q;
    assign out_addr    = out_addr_q;
    assign out_we      = pipe_we_o;
    assign out_wr_addr = pipe_addr_o;

    // Layer sequencing FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (last_issue) state <= (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
                S_DRAIN: if (pipe_we_o && pipe_last_o) state <= S_DONE;
                default: state <= start ? S_RUN : S_IDLE;
            endcase
        end
    end

    // Issue counters and registered addresses; the final issue leaves them holding its values
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            i_cnt      <= '0;
            j_cnt      <= '0;
            w_addr_q   <= W_BASE;
            in_addr_q  <= IN_BASE;
            out_addr_q <= OUT_BASE;
        end else if (issue && !last_issue) begin
            w_addr_q <= w_addr_q + ADDR_W'(1);
            if (last_in) begin
                i_cnt      <= '0;
                j_cnt      <= j_cnt + J_W'(1);
                in_addr_q  <= IN_BASE;
                out_addr_q <= out_addr_q + ADDR_W'(1);
            end else begin
                i_cnt     <= i_cnt + I_W'(1);
                in_addr_q <= in_addr_q + ADDR_W'(1);
            end
        end
    end

    // Write strobe pipeline matching the MAC latency; a final flag marks the layer's last neuron
    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign pipe_we_o   = iss_we;
            assign pipe_last_o = last_issue;
            assign pipe_addr_o = out_addr_q;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] we_sr;
            logic [PIPE_LAT-1:0] last_sr;
            logic [ADDR_W-1:0]   addr_sr [PIPE_LAT];

            // Shift every cycle regardless of stall; reset flushes any in-flight strobes
            always_ff @(posedge clk) begin
                if (reset) begin
                    we_sr   <= '0;
                    last_sr <= '0;
                    for (int k = 0; k < PIPE_LAT; k++) addr_sr[k] <= OUT_BASE;
                end else begin
                    we_sr[0]   <= iss_we;
                    last_sr[0] <= last_issue;
                    addr_sr[0] <= out_addr_q;
                    for (int k = 1; k < PIPE_LAT; k++) begin
                        we_sr[k]   <= we_sr[k-1];
                        last_sr[k] <= last_sr[k-1];
                        addr_sr[k] <= addr_sr[k-1];
                    end
                end
            end

            assign pipe_we_o   = we_sr[PIPE_LAT-1];
            assign pipe_last_o = last_sr[PIPE_LAT-1];
            assign pipe_addr_o = addr_sr[PIPE_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_layer_addr_gen.sv
// Directed bench for layer_addr_gen: default config, a wrapping PIPE_LAT=0 config and a PIPE_LAT=3 config.
// Cycle 0 is the cycle in which start is driven high; outputs are sampled on the falling edge.
// Inputs change 1 time unit after the rising edge.
module tb_layer_addr_gen;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // DUT A: defaults
    logic       a_start, a_stall, a_busy, a_done, a_av, a_ac, a_we;
    logic [7:0] a_wa, a_in, a_oa, a_owa;
    layer_addr_gen u_a (
        .clk(clk), .reset(reset), .start(a_start), .stall(a_stall),
        .busy(a_busy), .done(a_done), .addr_valid(a_av), .weight_addr(a_wa),
        .in_addr(a_in), .out_addr(a_oa), .acc_clear(a_ac), .out_we(a_we), .out_wr_addr(a_owa)
    );

    // DUT B: 3 inputs, 2 outputs, no pipeline, weight base near the wrap point
    logic       b_start, b_stall, b_busy, b_done, b_av, b_ac, b_we;
    logic [7:0] b_wa, b_in, b_oa, b_owa;
    layer_addr_gen #(.N_IN(3), .N_OUT(2), .PIPE_LAT(0), .W_BASE(8'hFE)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .stall(b_stall),
        .busy(b_busy), .done(b_done), .addr_valid(b_av), .weight_addr(b_wa),
        .in_addr(b_in), .out_addr(b_oa), .acc_clear(b_ac), .out_we(b_we), .out_wr_addr(b_owa)
    );

    // DUT C: defaults with a 3-deep write pipeline
    logic       c_start, c_stall, c_busy, c_done, c_av, c_ac, c_we;
    logic [7:0] c_wa, c_in, c_oa, c_owa;
    layer_addr_gen #(.PIPE_LAT(3)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .stall(c_stall),
        .busy(c_busy), .done(c_done), .addr_valid(c_av), .weight_addr(c_wa),
        .in_addr(c_in), .out_addr(c_oa), .acc_clear(c_ac), .out_we(c_we), .out_wr_addr(c_owa)
    );

    task automatic test_reset();
        reset = 1'b1;
        a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
        a_stall = 1'b0; b_stall = 1'b0; c_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if ({a_busy, a_done, a_av, a_ac, a_we} !== 5'b0)
            $display("FAIL reset_a_ctl got=%b exp=00000", {a_busy, a_done, a_av, a_ac, a_we});
        if ({a_busy, a_done, a_av, a_ac, a_we} !== 5'b0) n_fail++;
        n_tests++;
        if ({a_wa, a_in, a_oa, a_owa} !== 32'h0000_1010) begin
            n_fail++;
            $display("FAIL reset_a_addr got=%h exp=00001010", {a_wa, a_in, a_oa, a_owa});
        end
        n_tests++;
        if ({b_busy, b_done, b_av, b_ac, b_we, b_wa, b_in, b_oa, b_owa} !== {5'b0, 32'hFE00_1010}) begin
            n_fail++;
            $display("FAIL reset_b got=%h", {b_busy, b_done, b_av, b_ac, b_we, b_wa, b_in, b_oa, b_owa});
        end
        n_tests++;
        if ({c_busy, c_done, c_av, c_ac, c_we, c_wa, c_in, c_oa, c_owa} !== {5'b0, 32'h0000_1010}) begin
            n_fail++;
            $display("FAIL reset_c got=%h", {c_busy, c_done, c_av, c_ac, c_we, c_wa, c_in, c_oa, c_owa});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one default layer on DUT A; stall window [s0, s0+sn), extra start pulse at cycle mid
    task automatic run_def(input string nm, input int s0, input int sn, input int mid,
                           input int exp_done, input int we0);
        int         k;
        int         we_seen;
        bit         stl, iss, ewe;
        logic [7:0] ewa, ein, eoa, eowa;
        logic [4:0] exp_ctl;
        k = 0;
        we_seen = 0;
        for (int c = 0; c <= exp_done + 1; c++) begin
            stl = (c >= s0) && (c < s0 + sn);
            a_start = (c == 0) || (c == mid);
            a_stall = stl;
            @(negedge clk);
            iss  = (c >= 1) && !stl && (k < 16);
            ewa  = (k < 16) ? 8'(k) : 8'd15;
            ein  = ewa % 8'd4;
            eoa  = 8'h10 + ewa / 8'd4;
            ewe  = (we_seen < 4) && (c == we0 + 4 * we_seen);
            exp_ctl = {(c >= 1 && c < exp_done), (c == exp_done), iss, iss && (ein == 8'd0), ewe};
            n_tests++;
            if ({a_busy, a_done, a_av, a_ac, a_we} !== exp_ctl) begin
                n_fail++;
                $display("FAIL %s_ctl c=%0d got=%b exp=%b", nm, c, {a_busy, a_done, a_av, a_ac, a_we}, exp_ctl);
            end
            if (c >= 1) begin
                n_tests++;
                if ({a_wa, a_in, a_oa} !== {ewa, ein, eoa}) begin
                    n_fail++;
                    $display("FAIL %s_addr c=%0d got=%h exp=%h", nm, c, {a_wa, a_in, a_oa}, {ewa, ein, eoa});
                end
            end
            if (ewe) begin
                eowa = 8'h10 + 8'(we_seen);
                n_tests++;
                if (a_owa !== eowa) begin
                    n_fail++;
                    $display("FAIL %s_wraddr c=%0d got=%h exp=%h", nm, c, a_owa, eowa);
                end
                we_seen++;
            end
            if (iss) k++;
            @(posedge clk); #1;
        end
        a_start = 1'b0;
        a_stall = 1'b0;
    endtask

    task automatic test_basic();
        run_def("basic", 0, 0, -1, 18, 5);
    endtask

    task automatic test_stall();
        run_def("stall", 3, 2, -1, 20, 7);
    endtask

    task automatic test_start_ignored();
        run_def("midstart", 0, 0, 6, 18, 5);
    endtask

    task automatic test_back_to_back();
        int done2;
        done2 = -1;
        for (int c = 0; c <= 40; c++) begin
            a_start = (c == 0) || (c == 18);
            @(negedge clk);
            if (c == 18) begin
                n_tests++;
                if (a_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_done1 got=%b exp=1", a_done);
                end
            end
            if (c == 19) begin
                n_tests++;
                if ({a_busy, a_av, a_ac, a_wa} !== {3'b111, 8'h00}) begin
                    n_fail++;
                    $display("FAIL b2b_restart got=%h exp=%h", {a_busy, a_av, a_ac, a_wa}, {3'b111, 8'h00});
                end
            end
            if (c > 18 && a_done === 1'b1 && done2 < 0) done2 = c;
            @(posedge clk); #1;
        end
        a_start = 1'b0;
        n_tests++;
        if (done2 != 36) begin
            n_fail++;
            $display("FAIL b2b_done2 got=%0d exp=36", done2);
        end
    endtask

    task automatic test_reset_mid();
        logic [36:0] got;
        for (int c = 0; c <= 25; c++) begin
            a_start = (c == 0);
            reset = (c == 8);
            @(negedge clk);
            if (c >= 9) begin
                got = {a_busy, a_done, a_av, a_ac, a_we, a_wa, a_in, a_oa, a_owa};
                n_tests++;
                if (got !== {5'b0, 32'h0000_1010}) begin
                    n_fail++;
                    $display("FAIL rstmid c=%0d got=%h exp=%h", c, got, {5'b0, 32'h0000_1010});
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        a_start = 1'b0;
        run_def("fresh", 0, 0, -1, 18, 5);
    endtask

    task automatic test_wrap();
        logic [7:0] wa_tab [6];
        logic [7:0] ein, eoa;
        logic [4:0] exp_ctl;
        bit         iss;
        int         idx;
        wa_tab = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        for (int c = 0; c <= 8; c++) begin
            b_start = (c == 0);
            @(negedge clk);
            iss = (c >= 1) && (c <= 6);
            idx = iss ? c - 1 : 0;
            ein = 8'(idx % 3);
            eoa = 8'h10 + 8'(idx / 3);
            exp_ctl = {iss, (c == 7), iss, iss && (ein == 8'd0), iss && (ein == 8'd2)};
            n_tests++;
            if ({b_busy, b_done, b_av, b_ac, b_we} !== exp_ctl) begin
                n_fail++;
                $display("FAIL wrap_ctl c=%0d got=%b exp=%b", c, {b_busy, b_done, b_av, b_ac, b_we}, exp_ctl);
            end
            if (iss) begin
                n_tests++;
                if ({b_wa, b_in, b_oa, b_owa} !== {wa_tab[idx], ein, eoa, eoa}) begin
                    n_fail++;
                    $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, {b_wa, b_in, b_oa, b_owa},
                             {wa_tab[idx], ein, eoa, eoa});
                end
            end
            @(posedge clk); #1;
        end
        b_start = 1'b0;
    endtask

    task automatic test_pipe_lat();
        logic [2:0] exp_ctl;
        logic [7:0] eowa;
        bit         ewe;
        for (int c = 0; c <= 21; c++) begin
            c_start = (c == 0);
            @(negedge clk);
            ewe = (c == 7) || (c == 11) || (c == 15) || (c == 19);
            exp_ctl = {(c >= 1 && c <= 19), (c == 20), ewe};
            n_tests++;
            if ({c_busy, c_done, c_we} !== exp_ctl) begin
                n_fail++;
                $display("FAIL pipe3_ctl c=%0d got=%b exp=%b", c, {c_busy, c_done, c_we}, exp_ctl);
            end
            if (ewe) begin
                eowa = 8'h10 + 8'((c - 7) / 4);
                n_tests++;
                if (c_owa !== eowa) begin
                    n_fail++;
                    $display("FAIL pipe3_wraddr c=%0d got=%h exp=%h", c, c_owa, eowa);
                end
            end
            if (c >= 1 && c <= 16) begin
                n_tests++;
                if ({c_av, c_wa} !== {1'b1, 8'(c - 1)}) begin
                    n_fail++;
                    $display("FAIL pipe3_issue c=%0d got=%h exp=%h", c, {c_av, c_wa}, {1'b1, 8'(c - 1)});
                end
            end
            @(posedge clk); #1;
        end
        c_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_pipe_lat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_addr_gen.md
# layer_addr_gen

Parametrised address sequencer for one fully connected neural-network layer. Once started, it walks every (output neuron, input) pair and drives three addresses: weight-memory read, input-neuron read, and output-neuron write. It also emits accumulator-clear and write-enable strobes aligned to a fixed-latency MAC pipeline, plus a start/busy/done handshake. It sits between the layer controller and the weight/neuron RAMs, in front of the MAC datapath.

## Interface
Parameters:
- ADDR_W, 8, width of all address outputs
- N_IN, 4, inputs per neuron (≥1)
- N_OUT, 4, output neurons in layer (≥1)
- W_BASE, 8'h00, first weight address
- IN_BASE, 8'h00, first input-neuron address
- OUT_BASE, 8'h10, first output-neuron address
- PIPE_LAT, 1, cycles from issue of last input to the write strobe (0..8)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin layer; sampled only when busy=0
- stall  in  1  hold issue sequence for this cycle (RUN only)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at layer completion
- addr_valid  out  1  weight_addr/in_addr valid this cycle
- weight_addr  out  ADDR_W  weight RAM read address
- in_addr  out  ADDR_W  input-neuron RAM read address
- out_addr  out  ADDR_W  neuron currently being accumulated
- acc_clear  out  1  first input of a neuron is being issued
- out_we  out  1  write strobe for output RAM
- out_wr_addr  out  ADDR_W  write address, valid with out_we

## Operation
- Counters: i (0..N_IN-1) and j (0..N_OUT-1), each $clog2 width with a minimum of 1 bit.
- Address mapping for an issue: weight_addr = W_BASE + j*N_IN + i; in_addr = IN_BASE + i; out_addr = OUT_BASE + j. Sums are taken mod 2^ADDR_W (wrap, no error).
- Each issue cycle: addr_valid=1, and acc_clear=1 if i==0.
- Increment rule: i increments per issue. On i==N_IN-1, i returns to 0 and j increments.
- FSM states:
  - IDLE: start=1 → RUN, with i=j=0.
  - RUN: one issue per cycle unless stall=1. On stall, counters and addresses hold, and addr_valid=acc_clear=0. After the issue with i=N_IN-1 and j=N_OUT-1: go to DRAIN if PIPE_LAT>0, else to DONE.
  - DRAIN: wait until the final out_we has been emitted, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE. start is accepted here (busy=0) and goes directly to RUN.
- Write pipeline: a PIPE_LAT-deep shift register carries {is_last_input_issue, out_addr}. It shifts every cycle regardless of stall, so a stall inserts a bubble. Its output drives out_we/out_wr_addr. When PIPE_LAT=0, out_we/out_wr_addr are combinationally equal to the issue (last input, out_addr).
- start while busy=1: ignored. stall outside RUN: ignored.
- Reset at any time: state IDLE, pipeline flushed, no out_we or done issued for the aborted layer.

## Timing
- Reset values: busy=0, done=0, addr_valid=0, acc_clear=0, out_we=0. weight_addr=W_BASE, in_addr=IN_BASE, out_addr=OUT_BASE, out_wr_addr=OUT_BASE.
- Addresses are registered. With start high in cycle t, issue k (no stalls) appears in cycle t+1+k, for k=0..N_IN*N_OUT-1.
- out_we for neuron j appears PIPE_LAT cycles after its i=N_IN-1 issue.
- done appears 1 cycle after the final out_we. Total latency from start to done = N_IN*N_OUT + PIPE_LAT + 1 cycles plus the number of stall cycles.
- In IDLE/DONE, addresses hold their last value and addr_valid=0.

## Test plan
- Defaults, start in cycle 0, no stall:
  - weight_addr 0..15 in cycles 1..16; in_addr 0,1,2,3 repeating; out_addr 0x10..0x13, each held 4 cycles.
  - acc_clear in cycles 1,5,9,13.
  - out_we in cycles 5,9,13,17 with out_wr_addr 0x10..0x13.
  - done in cycle 18; busy=1 in cycles 1..17.
- Stall high in cycles 3–4: addr_valid=0 and addresses held at weight_addr=2 in those cycles. Sequence resumes at 2 in cycle 5; out_we in cycles 7,11,15,19; done in cycle 20.
- N_IN=3, N_OUT=2, PIPE_LAT=0, W_BASE=8'hFE: weight_addr FE,FF,00,01,02,03 (wrap). out_we coincides with issues 2 and 5. done one cycle after the last issue.
- start pulsed in cycle 6 mid-run: ignored, sequence identical to the first scenario. start held high in the done cycle: a new run begins, with weight_addr=0 in the next cycle.
- Reset asserted in cycle 8: from cycle 9, outputs at reset values, and no out_we or done follows. A fresh start afterwards reproduces the first scenario.
- PIPE_LAT=3, defaults otherwise: out_we in cycles 7,11,15,19; busy through cycle 19; done in cycle 20.
